nibble_reduce_stage: RTL and testbench

Registered ready/valid stage directly upstream of the `RTL` block. Accepts `WIDTH`-bit operand pairs (`in1`, `in2`), buffers them in a 2-entry skid FIFO, and presents each pair on the downstream handshake together with the precomputed reduction result `out = (|in1) && (&in1)`. This is exactly the relation the `RTL` bound monitor asserts while `handshake_valid` is high. The stage isolates `RTL` from upstream backpressure timing: no combinational path exists from `out_ready` to `in_ready`.

---
 rtl/nibble_reduce_pkg.sv | 40 ++++
 rtl/nibble_reduce_fifo2.sv | 70 +++++++
 rtl/nibble_reduce_stage.sv | 81 ++++++++
 tb/tb_nibble_reduce_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_reduce_pkg.sv
// nibble_reduce_pkg: shared types and the operand reduction for the
// nibble_reduce_stage slice. Optional feature macro of the top level:
// NIBBLE_REDUCE_STATS_EN.
package nibble_reduce_pkg;

  // Widest operand the stage supports; entries are stored at this width
  // and the top level uses only its low WIDTH bits.
  localparam int unsigned MAX_W = 32;

  // Occupancy of the 2-entry buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // One buffered pair plus its precomputed reduction.
  typedef struct packed {
    logic [MAX_W-1:0] in1;
    logic [MAX_W-1:0] in2;
    logic             red;
  } entry_t;

  // (|v) && (&v) over the low w bits of v.
  function automatic logic reduce_and_or(input logic [MAX_W-1:0] v,
                                         input int unsigned      w);
    logic v_and;
    logic v_or;
    v_and = 1'b1;
    v_or  = 1'b0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        v_and = v_and & v[i];
        v_or  = v_or | v[i];
      end
    end
    return v_or && v_and;
  endfunction

endpackage

// File: rtl/nibble_reduce_fifo2.sv
// nibble_reduce_fifo2: 2-entry skid buffer with 1-bit head/tail pointers
// and an occupancy FSM. Handshake: a push happens on a cycle where
// i_push_valid && o_push_ready, a pop where o_pop_valid && i_pop_ready;
// valid never depends on ready and o_push_ready depends only on the
// registered occupancy and reset, never on i_pop_ready.
module nibble_reduce_fifo2
  import nibble_reduce_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_push_valid,
  input  entry_t i_push_data,
  output logic   o_push_ready,
  output logic   o_pop_valid,
  input  logic   i_pop_ready,
  output entry_t o_head,
  output occ_e   o_occ
);

  occ_e   r_occ;
  occ_e   w_occ_next;
  entry_t r_mem [2];
  logic   r_wr_ptr;
  logic   r_rd_ptr;
  logic   w_push;
  logic   w_pop;

  assign o_push_ready = (r_occ != OCC_FULL) && !i_rst;
  assign o_pop_valid  = (r_occ != OCC_EMPTY);
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = o_pop_valid && i_pop_ready;
  assign o_head       = r_mem[r_rd_ptr];
  assign o_occ        = r_occ;

  // Next occupancy from the push/pop pair; simultaneous push+pop holds ONE.
  always_comb begin
    w_occ_next = r_occ;
    case (r_occ)
      OCC_EMPTY: if (w_push) w_occ_next = OCC_ONE;
      OCC_ONE: begin
        if (w_push && !w_pop)      w_occ_next = OCC_FULL;
        else if (w_pop && !w_push) w_occ_next = OCC_EMPTY;
      end
      OCC_FULL:  if (w_pop) w_occ_next = OCC_ONE;
      default:   w_occ_next = OCC_EMPTY;
    endcase
  end

  // Occupancy, pointers and storage; reset clears the entries so the
  // head reads as zero until the first push.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ    <= OCC_EMPTY;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      r_occ <= w_occ_next;
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

endmodule

// File: rtl/nibble_reduce_stage.sv
// nibble_reduce_stage: registered ready/valid stage that buffers operand
// pairs and presents each with out = (|in1) && (&in1), computed on push.
// Optional feature macro: NIBBLE_REDUCE_STATS_EN adds the saturating
// xfer_count output counting completed output transfers.
module nibble_reduce_stage
  import nibble_reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_in1,
  output logic [WIDTH-1:0] out_in2,
  output logic             out
`ifdef NIBBLE_REDUCE_STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_count
`endif
);

  entry_t w_push_data;
  entry_t w_head;
  occ_e   w_unused_occ;  // occupancy kept on a named net for probing

  // Legal parameter ranges; an illegal build leaves this marker block.
  if (WIDTH < 1 || WIDTH > MAX_W || CNT_W < 1) begin : g_bad_params
  end

  // Build the stored entry: zero-extended operands plus the reduction.
  always_comb begin
    w_push_data                = '0;
    w_push_data.in1[WIDTH-1:0] = in1;
    w_push_data.in2[WIDTH-1:0] = in2;
    w_push_data.red            = reduce_and_or(MAX_W'(in1), WIDTH);
  end

  nibble_reduce_fifo2 u_fifo (
    .i_clk        (CLK),
    .i_rst        (RESET),
    .i_push_valid (in_valid),
    .i_push_data  (w_push_data),
    .o_push_ready (in_ready),
    .o_pop_valid  (out_valid),
    .i_pop_ready  (out_ready),
    .o_head       (w_head),
    .o_occ        (w_unused_occ)
  );

  assign out_in1 = w_head.in1[WIDTH-1:0];
  assign out_in2 = w_head.in2[WIDTH-1:0];
  assign out     = w_head.red;

  // Upper storage bits are always zero when WIDTH is below MAX_W.
  if (WIDTH < MAX_W) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = |{w_head.in1[MAX_W-1:WIDTH], w_head.in2[MAX_W-1:WIDTH]};
  end

`ifdef NIBBLE_REDUCE_STATS_EN
  logic [CNT_W-1:0] r_xfer_count;

  // Count pops, saturating at all-ones; reset wins over a same-edge pop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_xfer_count <= '0;
    end else if (out_valid && out_ready && (r_xfer_count != '1)) begin
      r_xfer_count <= r_xfer_count + CNT_W'(1);
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_nibble_reduce_stage.sv
// tb_nibble_reduce_stage: directed and randomized checks of
// nibble_reduce_stage against a queue-based reference model.
// Honours NIBBLE_REDUCE_STATS_EN to also check xfer_count.
module tb_nibble_reduce_stage;

  localparam int W  = 4;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_in1;
  logic [W-1:0]  out_in2;
  logic          out;
  logic [CW-1:0] xfer_count;

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  nibble_reduce_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_in1    (out_in1),
    .out_in2    (out_in2),
    .out        (out)
`ifdef NIBBLE_REDUCE_STATS_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];   // {in1, in2} in acceptance order
  int             n_vec = 0;
  int             n_fail = 0;
  int             exp_cnt = 0;
  bit             last_push;
  bit             chk_zero;

  // Reference reduction: true only when in1 is non-zero and all ones.
  function automatic logic ref_red(input logic [W-1:0] x);
    int v;
    v = int'(x);
    return (v != 0) && (v == (1 << W) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model by what the
  // edge will do, then move to just after the rising edge.
  task automatic cycle();
    bit             exp_rdy;
    bit             do_pop;
    logic [2*W-1:0] head;
    @(negedge CLK);
    exp_rdy = !RESET && (exp_q.size() < 2);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("out_in1", out_in1, head[2*W-1:W]);
      chk("out_in2", out_in2, head[W-1:0]);
      chk("out", out, ref_red(head[2*W-1:W]));
    end else if (chk_zero) begin
      chk("zero_out_in1", out_in1, 0);
      chk("zero_out_in2", out_in2, 0);
      chk("zero_out", out, 0);
    end
`ifdef NIBBLE_REDUCE_STATS_EN
    chk("xfer_count", xfer_count, exp_cnt);
`endif
    last_push = 1'b0;
    if (RESET) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      do_pop = (exp_q.size() != 0) && out_ready;
      if (do_pop) begin
        void'(exp_q.pop_front());
        if (exp_cnt < (1 << CW) - 1) exp_cnt++;
      end
      if (in_valid && exp_rdy) begin
        exp_q.push_back({in1, in2});
        last_push = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // Offer one pair until the model says it was taken, bounded.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_push) break;
    end
    chk("send_accepted", last_push, 1);
    in_valid = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    RESET     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in1       = '0;
    in2       = '0;
    chk_zero  = 1'b0;
    @(posedge CLK);
    #1;

    // Reset held two cycles, then idle with zeroed outputs.
    cycle();
    cycle();
    RESET    = 1'b0;
    chk_zero = 1'b1;
    cycle();
    chk_zero = 1'b0;

    // Single pass through an empty stage.
    out_ready = 1'b1;
    send(4'hF, 4'h3);
    cycle();
    cycle();

    // Reduction values back-to-back.
    send(4'h0, 4'h1);
    send(4'h5, 4'h2);
    send(4'hF, 4'h4);
    cycle();
    cycle();

    // Backpressure: two absorbed, third held upstream, order preserved.
    out_ready = 1'b0;
    send(4'hA, 4'h1);
    send(4'hB, 4'h2);
    in_valid = 1'b1;
    in1      = 4'hC;
    in2      = 4'h3;
    cycle();
    cycle();
    cycle();
    out_ready = 1'b1;
    send(4'hC, 4'h3);
    cycle();
    cycle();
    cycle();

    // Sustained simultaneous push and pop at ONE for 8 cycles.
    send(4'h1, 4'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in1 = W'($urandom);
      in2 = W'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // Reset while FULL, then a fresh pair.
    out_ready = 1'b0;
    send(4'h2, 4'h2);
    send(4'h3, 4'h3);
    RESET     = 1'b1;
    out_ready = 1'b1;
    cycle();
    RESET    = 1'b0;
    chk_zero = 1'b1;
    cycle();
    chk_zero = 1'b0;
    send(4'h7, 4'h9);
    cycle();
    cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in1       = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom);
      in2       = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      RESET     = ($urandom_range(0, 59) == 0);
      cycle();
    end
    RESET    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
